// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the ROM and presents one
// instruction at a time to decode. Optional counters are enabled by FETCH_PERF_EN.
module fetch_ctrl #(
   parameter int unsigned     WIDTH       = 32,
   parameter int unsigned     INSTR_WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_i,
   input  logic [WIDTH-1:0]       redirect_target,
   input  logic                   halt_i,
   output logic [WIDTH-1:0]       imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [WIDTH-1:0]       instr_pc,
   output logic                   fault,
   output logic [WIDTH-1:0]       fault_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_stalled,
`endif
   output logic [1:0]             fsm_state
);

   // Handshake: an instruction transfers on a cycle where instr_valid && instr_ready;
   // instr and instr_pc stay stable while instr_valid && !instr_ready.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] pc_q;
   logic             load;
   logic             fire;
   logic             aligned;

   assign imem_addr = pc_q;
   assign fsm_state = state_q;
   assign load      = !instr_valid || instr_ready;
   assign fire      = instr_valid && instr_ready;
   assign aligned   = (redirect_target[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         fault       <= 1'b0;
         fault_pc    <= '0;
      end else begin
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (redirect_i && aligned) begin
                  pc_q        <= redirect_target;
                  instr_valid <= 1'b0;
               end else if (redirect_i) begin
                  state_q     <= FAULT;
                  fault       <= 1'b1;
                  fault_pc    <= redirect_target;
                  instr_valid <= 1'b0;
               end else if (halt_i) begin
                  state_q <= HALT;
                  // The held instruction may still be consumed on the way into HALT.
                  if (fire) instr_valid <= 1'b0;
               end else if (load) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc_q;
                  instr_valid <= 1'b1;
                  pc_q        <= pc_q + WIDTH'(4);
               end
            end
            HALT: begin
               if (redirect_i && aligned) begin
                  pc_q        <= redirect_target;
                  instr_valid <= 1'b0;
               end else if (redirect_i) begin
                  state_q     <= FAULT;
                  fault       <= 1'b1;
                  fault_pc    <= redirect_target;
                  instr_valid <= 1'b0;
               end else begin
                  if (!halt_i) state_q <= RUN;
                  if (fire) instr_valid <= 1'b0;
               end
            end
            FAULT: instr_valid <= 1'b0;
            default: state_q <= FAULT;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating event counters; they run in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stalled <= '0;
      end else begin
         if (instr_valid && instr_ready && (perf_fetched != 32'hFFFF_FFFF))
            perf_fetched <= perf_fetched + 32'd1;
         if (instr_valid && !instr_ready && (perf_stalled != 32'hFFFF_FFFF))
            perf_stalled <= perf_stalled + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a directed vector table on the default-PC instance
// plus hand sequences for async reset and PC wrap-around on a second instance.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst2 = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        halt_i = 1'b0;
   logic        instr_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, fault_pc;
   logic        instr_valid, fault;
   logic [1:0]  fsm_state;

   logic        ready2 = 1'b0;
   logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2, fault_pc2;
   logic        instr_valid2, fault2;
   logic [1:0]  fsm_state2;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stalled, perf_fetched2, perf_stalled2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // ROM model: word i holds value i
   assign imem_rdata  = {2'b00, imem_addr[31:2]};
   assign imem_rdata2 = {2'b00, imem_addr2[31:2]};

   fetch_ctrl #(.WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_target(redirect_target),
      .halt_i(halt_i), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .fault(fault), .fault_pc(fault_pc),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_stalled(perf_stalled),
`endif
      .fsm_state(fsm_state)
   );

   fetch_ctrl #(.WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst2), .redirect_i(1'b0), .redirect_target(32'h0),
      .halt_i(1'b0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .instr_valid(instr_valid2), .instr_ready(ready2), .instr(instr2),
      .instr_pc(instr_pc2), .fault(fault2), .fault_pc(fault_pc2),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched2), .perf_stalled(perf_stalled2),
`endif
      .fsm_state(fsm_state2)
   );

   typedef struct {
      logic        redirect;
      logic [31:0] target;
      logic        halt;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_addr;
      logic        exp_fault;
      logic [31:0] exp_fault_pc;
      logic [1:0]  exp_state;
   } vec_t;

   vec_t vecs[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%08h expected 'h%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic rd, input logic [31:0] tg, input logic hl,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ei, input logic [31:0] ea, input logic ef,
                               input logic [31:0] efp, input logic [1:0] es);
      vec_t v;
      v.redirect = rd; v.target = tg; v.halt = hl; v.ready = rdy;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ei; v.exp_addr = ea;
      v.exp_fault = ef; v.exp_fault_pc = efp; v.exp_state = es;
      return v;
   endfunction

   initial begin
      // Each row: inputs applied for one cycle, then expected outputs after that edge.
      //            rd  target  hl rdy  v  pc      instr   addr    f  fpc    state
      vecs[0]  = mk(0, 32'h0,   0, 1,  0, 32'h0,  32'h0,  32'h0,  0, 32'h0, 2'd1); // BOOT->RUN
      vecs[1]  = mk(0, 32'h0,   0, 1,  1, 32'h0,  32'h0,  32'h4,  0, 32'h0, 2'd1);
      vecs[2]  = mk(0, 32'h0,   0, 1,  1, 32'h4,  32'h1,  32'h8,  0, 32'h0, 2'd1);
      vecs[3]  = mk(0, 32'h0,   0, 1,  1, 32'h8,  32'h2,  32'hC,  0, 32'h0, 2'd1);
      vecs[4]  = mk(0, 32'h0,   0, 0,  1, 32'h8,  32'h2,  32'hC,  0, 32'h0, 2'd1); // stall
      vecs[5]  = mk(0, 32'h0,   0, 0,  1, 32'h8,  32'h2,  32'hC,  0, 32'h0, 2'd1);
      vecs[6]  = mk(0, 32'h0,   0, 0,  1, 32'h8,  32'h2,  32'hC,  0, 32'h0, 2'd1);
      vecs[7]  = mk(0, 32'h0,   0, 1,  1, 32'hC,  32'h3,  32'h10, 0, 32'h0, 2'd1);
      vecs[8]  = mk(0, 32'h0,   0, 1,  1, 32'h10, 32'h4,  32'h14, 0, 32'h0, 2'd1);
      vecs[9]  = mk(1, 32'h40,  0, 1,  0, 32'h0,  32'h0,  32'h40, 0, 32'h0, 2'd1); // redirect
      vecs[10] = mk(0, 32'h0,   0, 1,  1, 32'h40, 32'h10, 32'h44, 0, 32'h0, 2'd1);
      vecs[11] = mk(0, 32'h0,   1, 0,  1, 32'h40, 32'h10, 32'h44, 0, 32'h0, 2'd2); // halt
      vecs[12] = mk(0, 32'h0,   1, 0,  1, 32'h40, 32'h10, 32'h44, 0, 32'h0, 2'd2);
      vecs[13] = mk(0, 32'h0,   1, 1,  0, 32'h0,  32'h0,  32'h44, 0, 32'h0, 2'd2); // drain
      vecs[14] = mk(0, 32'h0,   1, 1,  0, 32'h0,  32'h0,  32'h44, 0, 32'h0, 2'd2);
      vecs[15] = mk(0, 32'h0,   0, 1,  0, 32'h0,  32'h0,  32'h44, 0, 32'h0, 2'd1);
      vecs[16] = mk(0, 32'h0,   0, 1,  1, 32'h44, 32'h11, 32'h48, 0, 32'h0, 2'd1);
      vecs[17] = mk(0, 32'h0,   1, 0,  1, 32'h44, 32'h11, 32'h48, 0, 32'h0, 2'd2);
      vecs[18] = mk(1, 32'h80,  1, 0,  0, 32'h0,  32'h0,  32'h80, 0, 32'h0, 2'd2); // halt redirect
      vecs[19] = mk(0, 32'h0,   0, 0,  0, 32'h0,  32'h0,  32'h80, 0, 32'h0, 2'd1);
      vecs[20] = mk(0, 32'h0,   0, 1,  1, 32'h80, 32'h20, 32'h84, 0, 32'h0, 2'd1);
      vecs[21] = mk(1, 32'h42,  0, 0,  0, 32'h0,  32'h0,  32'h84, 1, 32'h42, 2'd3); // misaligned
      vecs[22] = mk(1, 32'h100, 1, 1,  0, 32'h0,  32'h0,  32'h84, 1, 32'h42, 2'd3);
      vecs[23] = mk(0, 32'h0,   0, 1,  0, 32'h0,  32'h0,  32'h84, 1, 32'h42, 2'd3);

      // Wrap-around instance, RESET_PC = FFFF_FFF8
      ready2 = 1'b1;
      step(); step();
      rst2 = 1'b0;
      step();
      chk("wrap_boot_valid", {31'b0, instr_valid2}, 32'h0);
      step();
      chk("wrap_valid0", {31'b0, instr_valid2}, 32'h1);
      chk("wrap_pc0", instr_pc2, 32'hFFFF_FFF8);
      chk("wrap_instr0", instr2, 32'h3FFF_FFFE);
      ready2 = 1'b0;
      step(); step();
      chk("wrap_stall_pc", instr_pc2, 32'hFFFF_FFF8);
      chk("wrap_stall_addr", imem_addr2, 32'hFFFF_FFFC);
      ready2 = 1'b1;
      step();
      chk("wrap_pc1", instr_pc2, 32'hFFFF_FFFC);
      chk("wrap_instr1", instr2, 32'h3FFF_FFFF);
      step();
      chk("wrap_pc2", instr_pc2, 32'h0);
      chk("wrap_instr2", instr2, 32'h0);
      step();
      chk("wrap_pc3", instr_pc2, 32'h4);
      ready2 = 1'b0;
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched2, 32'd3);
      chk("perf_stalled", perf_stalled2, 32'd2);
`endif

      // Reset state of the main instance
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_state", {30'b0, fsm_state}, 32'h0);

      for (int i = 0; i < 24; i++) begin
         redirect_i      = vecs[i].redirect;
         redirect_target = vecs[i].target;
         halt_i          = vecs[i].halt;
         instr_ready     = vecs[i].ready;
         step();
         chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].exp_fault});
         chk($sformatf("v%0d_fault_pc", i), fault_pc, vecs[i].exp_fault_pc);
         chk($sformatf("v%0d_state", i), {30'b0, fsm_state}, {30'b0, vecs[i].exp_state});
         if (vecs[i].exp_valid) begin
            chk($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
         end
      end
      redirect_i = 1'b0;
      halt_i     = 1'b0;

      // Async reset clears the fault, then fetch restarts; reset again mid-handshake
      #2 rst = 1'b1;
      #1;
      chk("async_rst_fault", {31'b0, fault}, 32'h0);
      chk("async_rst_fault_pc", fault_pc, 32'h0);
      chk("async_rst_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      instr_ready = 1'b0;
      step(); step();
      chk("restart_valid", {31'b0, instr_valid}, 32'h1);
      chk("restart_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("midhs_rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("midhs_rst_instr", instr, 32'h0);
      chk("midhs_rst_state", {30'b0, fsm_state}, 32'h0);
`ifdef FETCH_PERF_EN
      chk("perf_rst", perf_fetched, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
